// File: rtl/arbitrated_merge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arbitrated_merge: round-robin merge of two 4-phase bundled-data channels  |
// | into one, with programmable forward and backward latency.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module arbitrated_merge #(
  parameter int WIDTH = 49,
  parameter int FL    = 2,
  parameter int BL    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A_req,
  input  logic [WIDTH-1:0] A_data,
  output logic             A_ack,
  input  logic             B_req,
  input  logic [WIDTH-1:0] B_data,
  output logic             B_ack,
  output logic             O_req,
  output logic [WIDTH-1:0] O_data,
  input  logic             O_ack
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_IN_ACK  = 3'd1,
    S_WAIT_FL = 3'd2,
    S_OUT_REQ = 3'd3,
    S_OUT_RTZ = 3'd4,
    S_WAIT_BL = 3'd5
  } state_t;

  localparam logic [7:0] C_FL_LAST = (FL > 0) ? 8'(FL - 1) : 8'd0;
  localparam logic [7:0] C_BL_LAST = (BL > 0) ? 8'(BL - 1) : 8'd0;

  state_t             r_state;
  state_t             w_state;
  logic [7:0]         r_cnt;
  logic [7:0]         w_cnt;
  logic               r_a_ack;
  logic               w_a_ack;
  logic               r_b_ack;
  logic               w_b_ack;
  logic               r_o_req;
  logic               w_o_req;
  logic [WIDTH-1:0]   r_o_data;
  logic [WIDTH-1:0]   w_o_data;
  logic               r_last_b;
  logic               w_last_b;
  logic               w_grant_a;
  logic               w_grant_b;
  logic               w_winner_req;

  // On a tie the channel not served last time wins.
  assign w_grant_a    = A_req && (!B_req || r_last_b);
  assign w_grant_b    = B_req && (!A_req || !r_last_b);
  assign w_winner_req = r_last_b ? B_req : A_req;

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_a_ack  = r_a_ack;
    w_b_ack  = r_b_ack;
    w_o_req  = r_o_req;
    w_o_data = r_o_data;
    w_last_b = r_last_b;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant_a) begin
          w_o_data = A_data;
          w_last_b = 1'b0;
          w_a_ack  = 1'b1;
          w_state  = S_IN_ACK;
        end else if (w_grant_b) begin
          w_o_data = B_data;
          w_last_b = 1'b1;
          w_b_ack  = 1'b1;
          w_state  = S_IN_ACK;
        end
      end
      S_IN_ACK: begin
        if (!w_winner_req) begin
          w_a_ack = 1'b0;
          w_b_ack = 1'b0;
          w_cnt   = 8'd0;
          if (FL == 0) begin
            w_o_req = 1'b1;
            w_state = S_OUT_REQ;
          end else begin
            w_state = S_WAIT_FL;
          end
        end
      end
      S_WAIT_FL: begin
        if (r_cnt == C_FL_LAST) begin
          w_o_req = 1'b1;
          w_state = S_OUT_REQ;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      S_OUT_REQ: begin
        if (O_ack) begin
          w_o_req = 1'b0;
          w_state = S_OUT_RTZ;
        end
      end
      S_OUT_RTZ: begin
        if (!O_ack) begin
          w_cnt = 8'd0;
          if (BL == 0) begin
            w_state = S_IDLE;
          end else begin
            w_state = S_WAIT_BL;
          end
        end
      end
      S_WAIT_BL: begin
        if (r_cnt == C_BL_LAST) begin
          w_state = S_IDLE;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // Reset aborts any transaction; last-granted starts at B so the first tie goes to A.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_a_ack  <= 1'b0;
      r_b_ack  <= 1'b0;
      r_o_req  <= 1'b0;
      r_o_data <= '0;
      r_last_b <= 1'b1;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_a_ack  <= w_a_ack;
      r_b_ack  <= w_b_ack;
      r_o_req  <= w_o_req;
      r_o_data <= w_o_data;
      r_last_b <= w_last_b;
    end
  end

  assign A_ack  = r_a_ack;
  assign B_ack  = r_b_ack;
  assign O_req  = r_o_req;
  assign O_data = r_o_data;

endmodule
`default_nettype wire

// File: tb/tb_arbitrated_merge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_arbitrated_merge: directed scoreboard bench for arbitrated_merge.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_arbitrated_merge;
  localparam int W = 49;

  logic         clk = 1'b0;
  logic         rst;
  logic         a_req, b_req, a_ack, b_ack, o_req, o_ack;
  logic [W-1:0] a_data, b_data, o_data;

  logic         z_breq, z_back, z_aack, z_oreq, z_oack;
  logic [W-1:0] z_bdata, z_odata;

  int           n_cmp = 0;
  int           n_err = 0;
  int           ack_delay = 0;
  int           hold_cnt = 0;
  logic [W-1:0] held;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] z_q[$];

  always #5 clk = ~clk;

  arbitrated_merge #(.WIDTH(W), .FL(2), .BL(1)) dut (
    .clk(clk), .rst(rst),
    .A_req(a_req), .A_data(a_data), .A_ack(a_ack),
    .B_req(b_req), .B_data(b_data), .B_ack(b_ack),
    .O_req(o_req), .O_data(o_data), .O_ack(o_ack)
  );

  arbitrated_merge #(.WIDTH(W), .FL(0), .BL(0)) dut0 (
    .clk(clk), .rst(rst),
    .A_req(1'b0), .A_data({W{1'b0}}), .A_ack(z_aack),
    .B_req(z_breq), .B_data(z_bdata), .B_ack(z_back),
    .O_req(z_oreq), .O_data(z_odata), .O_ack(z_oack)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output receiver for the main DUT: optional ack delay, scoreboard pop on ack.
  always @(negedge clk) begin
    if (!rst) check("ack_exclusive", {a_ack, b_ack} == 2'b11, 0);
    if (rst) begin
      o_ack    = 1'b0;
      hold_cnt = 0;
    end else if (o_req && !o_ack) begin
      if (hold_cnt == 0) held = o_data;
      else begin
        check("o_data_stable", o_data, held);
        check("in_ack_quiet", {a_ack, b_ack}, 0);
      end
      if (hold_cnt < ack_delay) hold_cnt++;
      else begin
        check("exp_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("o_data", o_data, exp_q.pop_front());
        o_ack    = 1'b1;
        hold_cnt = 0;
      end
    end else begin
      if (!o_req) hold_cnt = 0;
      if (!o_req && o_ack) o_ack = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (z_oreq && !z_oack) begin
      check("z_exp_nonempty", z_q.size() != 0, 1);
      if (z_q.size() != 0) check("z_o_data", z_odata, z_q.pop_front());
      z_oack = 1'b1;
    end else if (!z_oreq && z_oack) begin
      z_oack = 1'b0;
    end
  end

  task automatic send_a(input logic [W-1:0] d, output int lat);
    int k;
    @(negedge clk);
    a_data = d;
    a_req  = 1'b1;
    k = 0;
    while (!a_ack && k < 300) begin @(negedge clk); k++; end
    lat = k;
    check("a_ack_rise", a_ack, 1);
    a_req = 1'b0;
    k = 0;
    while (a_ack && k < 300) begin @(negedge clk); k++; end
    check("a_ack_fall", a_ack, 0);
  endtask

  task automatic send_b(input logic [W-1:0] d);
    int k;
    @(negedge clk);
    b_data = d;
    b_req  = 1'b1;
    k = 0;
    while (!b_ack && k < 300) begin @(negedge clk); k++; end
    check("b_ack_rise", b_ack, 1);
    b_req = 1'b0;
    k = 0;
    while (b_ack && k < 300) begin @(negedge clk); k++; end
    check("b_ack_fall", b_ack, 0);
  endtask

  task automatic send_z(input logic [W-1:0] d);
    int k;
    @(negedge clk);
    z_bdata = d;
    z_breq  = 1'b1;
    k = 0;
    while (!z_back && k < 300) begin @(negedge clk); k++; end
    check("z_b_ack_rise", z_back, 1);
    z_breq = 1'b0;
    k = 0;
    while (z_back && k < 300) begin @(negedge clk); k++; end
    check("z_b_ack_fall", z_back, 0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || o_req || o_ack) && k < 500) begin @(negedge clk); k++; end
    check("drain_exp_q", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat2, k;
    rst = 1'b1;
    a_req = 1'b0; b_req = 1'b0; a_data = '0; b_data = '0;
    z_breq = 1'b0; z_bdata = '0;
    o_ack = 1'b0; z_oack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_o_req", o_req, 0);
    check("rst_a_ack", a_ack, 0);
    check("rst_b_ack", b_ack, 0);
    check("rst_o_data", o_data, 0);
    rst = 1'b0;

    // Single A packet: ack one cycle after req; O_req two edges after the edge that sees req low.
    exp_q.push_back(49'h1_2345_6789);
    send_a(49'h1_2345_6789, lat);
    check("a_ack_latency", lat, 1);
    k = 1;
    while (!o_req && k < 50) begin @(negedge clk); k++; end
    check("fl_latency", k, 3);
    drain();

    // Simultaneous requests right after reset: A first, B held off.
    pulse_reset();
    exp_q.push_back(49'h0AA);
    exp_q.push_back(49'h0BB);
    fork
      send_a(49'h0AA, lat);
      send_b(49'h0BB);
      begin
        k = 0;
        while (exp_q.size() == 2 && k < 200) begin
          check("b_ack_held_low", b_ack, 0);
          @(negedge clk);
          k++;
        end
      end
    join
    drain();

    // Continuous contention: strict alternation starting with A.
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(49'h100 + 49'(i));
      exp_q.push_back(49'h200 + 49'(i));
    end
    fork
      for (int i = 0; i < 3; i++) send_a(49'h100 + 49'(i), lat);
      for (int j = 0; j < 3; j++) send_b(49'h200 + 49'(j));
    join
    drain();

    // Slow receiver with a pending B request.
    ack_delay = 5;
    exp_q.push_back(49'h1_CAFE_0001);
    exp_q.push_back(49'h0_BEEF_0002);
    fork
      send_a(49'h1_CAFE_0001, lat);
      begin
        repeat (3) @(negedge clk);
        send_b(49'h0_BEEF_0002);
      end
    join
    drain();
    ack_delay = 0;

    // Reset during OUT_REQ aborts the packet and restores A priority on ties.
    ack_delay = 1000;
    exp_q.push_back(49'h0DEAD);
    send_a(49'h0DEAD, lat);
    k = 0;
    while (!o_req && k < 50) begin @(negedge clk); k++; end
    check("abort_o_req_up", o_req, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_o_req", o_req, 0);
    check("abort_a_ack", a_ack, 0);
    check("abort_b_ack", b_ack, 0);
    check("abort_o_data", o_data, 0);
    exp_q.delete();
    ack_delay = 0;
    rst = 1'b0;
    exp_q.push_back(49'h0A1);
    exp_q.push_back(49'h0B1);
    fork
      send_a(49'h0A1, lat2);
      send_b(49'h0B1);
    join
    drain();

    // Zero-latency instance: O_req up on the edge after B_req falls.
    for (int i = 0; i < 3; i++) begin
      z_q.push_back(49'h0_5000 + 49'(i));
      send_z(49'h0_5000 + 49'(i));
      check("z_o_req_edge", z_oreq, 1);
    end
    k = 0;
    while ((z_q.size() != 0 || z_oreq || z_oack) && k < 200) begin @(negedge clk); k++; end
    check("z_drain", z_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arbitrated_merge.md
ARBITRATED_MERGE -- requirements
Module: arbitrated_merge

Interface
REQ-001 Parameter WIDTH, default 49: packet width in bits; all data ports are WIDTH wide.
REQ-002 Parameter FL, default 2: forward latency in clock cycles; legal range 0..255.
REQ-003 Parameter BL, default 1: backward latency in clock cycles; legal range 0..255.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port A_req, input, 1: request from input channel A.
REQ-007 Port A_data, input, WIDTH: A payload, stable while A_req=1.
REQ-008 Port A_ack, output, 1: acknowledge to A.
REQ-009 Ports B_req (input, 1), B_data (input, WIDTH) and B_ack (output, 1): same roles as the A ports, for channel B.
REQ-010 Port O_req, output, 1: request on the merged output channel.
REQ-011 Port O_data, output, WIDTH: merged payload.
REQ-012 Port O_ack, input, 1: acknowledge from the output receiver.

Function
REQ-013 Every channel SHALL use a 4-phase bundled-data handshake: req rises with data valid, ack rises, req falls, ack falls.
REQ-014 The block SHALL be a registered FSM with states IDLE, IN_ACK, WAIT_FL, OUT_REQ, OUT_RTZ and WAIT_BL; all outputs come from registers.
REQ-015 IDLE: if exactly one of A_req/B_req is 1, that input wins; if neither is 1, the FSM stays in IDLE.
REQ-016 IDLE, both requests 1: the input not granted last time wins (round-robin); the first tie after reset goes to A.
REQ-017 On a grant, the FSM SHALL latch the winner's data into O_data, record the winner as last-granted, set the winner's ack to 1 and enter IN_ACK.
REQ-018 IN_ACK: hold the winner's ack at 1 until the winner's req is 0, then clear the ack and enter WAIT_FL; the loser's ack stays 0.
REQ-019 WAIT_FL: wait FL cycles, then set O_req=1 and enter OUT_REQ; with FL=0, O_req rises on the edge that leaves IN_ACK.
REQ-020 OUT_REQ: hold O_req=1 until O_ack=1, then clear O_req and enter OUT_RTZ.
REQ-021 OUT_RTZ: wait until O_ack=0, then enter WAIT_BL.
REQ-022 WAIT_BL: wait BL cycles, then return to IDLE; with BL=0, go directly to IDLE.
REQ-023 O_data SHALL remain stable from the grant edge until the next grant, so it is stable whenever O_req=1.
REQ-024 A request that arrives while the FSM is not in IDLE SHALL wait; no packet is dropped, duplicated or reordered within one input.
REQ-025 An O_ack that rises without an outstanding O_req SHALL be ignored.
REQ-026 A_ack and B_ack SHALL never both be 1.

Reset
REQ-027 While rst=1 at a rising edge, the block SHALL set: state IDLE, A_ack=0, B_ack=0, O_req=0, O_data=0, last-granted=B.
REQ-028 Reset asserted mid-transaction SHALL abort it; the in-flight packet is discarded, and all outputs follow REQ-027 on that edge.
REQ-029 No grant SHALL occur on an edge where rst=1.

Verification
REQ-030 Single A packet, FL=2, BL=1: A_data=0x1_2345_6789 -> A_ack rises 1 cycle after A_req; after A_req falls, O_req rises FL cycles later with O_data=0x1_2345_6789.
REQ-031 A and B both request in the same cycle after reset (A=0xAA, B=0xBB) -> output order 0xAA then 0xBB; B_ack stays 0 until the A transaction completes.
REQ-032 Both inputs continuously requesting for 6 packets -> grants alternate A,B,A,B,A,B.
REQ-033 Output receiver delays O_ack by 5 cycles -> O_req holds and O_data stays constant for those cycles; no input ack during OUT_REQ.
REQ-034 rst pulsed while in OUT_REQ -> next edge O_req=0, acks=0, O_data=0; the next tie after reset goes to A.
REQ-035 FL=0, BL=0, back-to-back B packets -> each packet delivered in order; O_req rises on the edge after B_req falls.
